// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and constants for the multicycle control unit slice.
// Package mc_ctrl_pkg:
//   state_t  - FSM states of the fetch/decode/execute/writeback sequencer
//   cond_t   - condition field encodings (instr[31:28])
//   ALU_*    - alu_control encodings
//   CMD_*    - data-processing cmd field encodings (funct[4:1])
//   OP_*     - instruction class encodings (instr[27:26])
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_BAD = 3'b111;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the multicycle control unit and its datapath.
// master: the control unit (consumes instruction fields, flags, mem_ready;
//         drives datapath mux selects, write enables, alu_control, status pulses)
// slave : the datapath side (mirror directions)
interface multicycle_control_unit_if #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned REG_IDX_W  = 4
);
  logic [1:0]            op;
  logic [5:0]            funct;
  logic [REG_IDX_W-1:0]  rd;
  logic [3:0]            cond;
  logic [3:0]            alu_flags;
  logic                  mem_ready;

  logic                  pc_write;
  logic                  ir_write;
  logic                  reg_w;
  logic                  mem_w;
  logic                  adr_src;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            result_src;
  logic [1:0]            imm_src;
  logic [1:0]            reg_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  instr_done;
  logic                  illegal;

  modport master (
    input  op, funct, rd, cond, alu_flags, mem_ready,
    output pc_write, ir_write, reg_w, mem_w, adr_src, alu_src_a,
           alu_src_b, result_src, imm_src, reg_src, alu_control,
           instr_done, illegal
  );

  modport slave (
    output op, funct, rd, cond, alu_flags, mem_ready,
    input  pc_write, ir_write, reg_w, mem_w, adr_src, alu_src_a,
           alu_src_b, result_src, imm_src, reg_src, alu_control,
           instr_done, illegal
  );
endinterface

// File: rtl/multicycle_control_unit_cond_check.sv
// Condition evaluator: cond (instr[31:28]) against NZCV flags -> cond_ex.
// Ports: cond[3:0] in, flags[3:0] in ({N,Z,C,V}), cond_ex out.
module cond_check
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_t'(cond))
      C_EQ: cond_ex = z;
      C_NE: cond_ex = ~z;
      C_CS: cond_ex = c;
      C_CC: cond_ex = ~c;
      C_MI: cond_ex = n;
      C_PL: cond_ex = ~n;
      C_VS: cond_ex = v;
      C_VC: cond_ex = ~v;
      C_HI: cond_ex = c & ~z;
      C_LS: cond_ex = ~c | z;
      C_GE: cond_ex = (n == v);
      C_LT: cond_ex = (n != v);
      C_GT: cond_ex = ~z & (n == v);
      C_LE: cond_ex = z | (n != v);
      C_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/writeback
// (3-5 cycles per instruction), NZCV flag register, conditional-execution gating
// of register/memory/PC writes, ALU decode and datapath mux selects.
// Ports: clk, rst_n (synchronous, active low), bus (multicycle_control_unit_if.master).
// Optional build macro MULTICYCLE_MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until
// mem_ready=1; without it mem_ready is ignored and those states last one cycle.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned REG_IDX_W  = 4,
  parameter int unsigned PC_REG     = 15
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);
  state_t     state, next;
  logic [3:0] flags;
  logic       cond_ex, cond_ex_q;
  logic [3:0] cmd;
  logic [2:0] alu_dec;
  logic       cmd_bad, mem_go;
  logic       ir_raw, pcf_raw, regw_raw, memw_raw, branch, alu_op, done_raw, ill_raw;

  assign cmd = bus.funct[4:1];

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_go = bus.mem_ready;
`else
  logic mem_ready_unused;
  assign mem_go           = 1'b1;
  assign mem_ready_unused = bus.mem_ready;
`endif

  cond_check u_cond_check (
    .cond    (bus.cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  always_comb begin
    alu_dec = ALU_BAD;
    cmd_bad = 1'b0;
    case (cmd)
      CMD_ADD: alu_dec = ALU_ADD;
      CMD_SUB: alu_dec = ALU_SUB;
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      CMD_CMP: alu_dec = ALU_SUB;
      default: cmd_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags     <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      if (state == S_DECODE) cond_ex_q <= cond_ex;
      if ((state == S_EXECR || state == S_EXECI) && bus.funct[0] && cond_ex_q) begin
        flags[3:2] <= bus.alu_flags[3:2];
        if (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP)
          flags[1:0] <= bus.alu_flags[1:0];
      end
    end
  end

  always_comb begin
    next           = state;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.result_src = 2'b00;
    ir_raw   = 1'b0;
    pcf_raw  = 1'b0;
    regw_raw = 1'b0;
    memw_raw = 1'b0;
    branch   = 1'b0;
    alu_op   = 1'b0;
    done_raw = 1'b0;
    ill_raw  = 1'b0;
    case (state)
      S_FETCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        if (mem_go) begin
          ir_raw  = 1'b1;
          pcf_raw = 1'b1;
          next    = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        case (bus.op)
          OP_MEM: next = S_MEMADR;
          OP_BR:  next = S_BRANCH;
          OP_DP: begin
            // An unknown cmd ends the instruction here, same as op=11,
            // so the done pulse in DECODE really marks its last state.
            if (cmd_bad) begin
              ill_raw  = 1'b1;
              done_raw = 1'b1;
              next     = S_FETCH;
            end else begin
              next = bus.funct[5] ? S_EXECI : S_EXECR;
            end
          end
          default: begin
            ill_raw  = 1'b1;
            done_raw = 1'b1;
            next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_b = 2'b01;
        next = bus.funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.adr_src = 1'b1;
        if (mem_go) next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        regw_raw = 1'b1;
        done_raw = 1'b1;
        next     = S_FETCH;
      end
      S_MEMWR: begin
        bus.adr_src = 1'b1;
        if (mem_go) begin
          memw_raw = 1'b1;
          done_raw = 1'b1;
          next     = S_FETCH;
        end
      end
      S_EXECR: begin
        bus.alu_src_b = 2'b00;
        alu_op = 1'b1;
        next   = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_b = 2'b01;
        alu_op = 1'b1;
        next   = S_ALUWB;
      end
      S_ALUWB: begin
        bus.result_src = 2'b00;
        regw_raw = (cmd != CMD_CMP);
        done_raw = 1'b1;
        next     = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_b  = 2'b01;
        bus.result_src = 2'b10;
        branch   = 1'b1;
        done_raw = 1'b1;
        next     = S_FETCH;
      end
      default: next = S_FETCH;
    endcase
  end

  assign bus.ir_write   = rst_n & ir_raw;
  assign bus.reg_w      = rst_n & regw_raw & cond_ex_q;
  assign bus.mem_w      = rst_n & memw_raw & cond_ex_q;
  assign bus.pc_write   = rst_n & (pcf_raw | (cond_ex_q & (branch |
                          (regw_raw & (bus.rd == REG_IDX_W'(PC_REG))))));
  assign bus.instr_done = rst_n & done_raw;
  assign bus.illegal    = rst_n & ill_raw;

  assign bus.alu_control = ALU_CTRL_W'(alu_op ? alu_dec : ALU_ADD);
  assign bus.imm_src     = bus.op;
  assign bus.reg_src     = {bus.op == OP_MEM, bus.op == OP_BR};
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the driver issues one
// instruction at a time and pushes the hand-computed per-instruction summary;
// the monitor accumulates enables over the instruction and compares on instr_done.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_CTRL_W(3), .REG_IDX_W(4)) bus ();

  multicycle_control_unit #(.ALU_CTRL_W(3), .REG_IDX_W(4), .PC_REG(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    int         cyc;
    int         regw;
    int         memw;
    int         pcw;
    int         ill;
    logic [1:0] rs;
    logic [2:0] alu;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s instr=%0d got=%0d want=%0d", name, id, act, exp);
    end
  endfunction

  // Monitor
  int m_cyc, m_regw, m_memw, m_pcw, m_ill;
  logic [2:0] m_alu;
  initial begin
    exp_t e;
    m_cyc = 0; m_regw = 0; m_memw = 0; m_pcw = 0; m_ill = 0; m_alu = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        m_cyc = 0; m_regw = 0; m_memw = 0; m_pcw = 0; m_ill = 0; m_alu = '0;
      end else begin
        m_cyc++;
        m_regw += int'(bus.reg_w);
        m_memw += int'(bus.mem_w);
        m_pcw  += int'(bus.pc_write);
        m_ill  += int'(bus.illegal);
        m_alu  |= bus.alu_control;
        if (bus.instr_done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", -1, 1, 0);
          end else begin
            e = q.pop_front();
            chk("cycles",     e.id, m_cyc,  e.cyc);
            chk("reg_w",      e.id, m_regw, e.regw);
            chk("mem_w",      e.id, m_memw, e.memw);
            chk("pc_write",   e.id, m_pcw,  e.pcw);
            chk("illegal",    e.id, m_ill,  e.ill);
            chk("result_src", e.id, int'(bus.result_src), int'(e.rs));
            chk("alu_ctrl",   e.id, int'(m_alu), int'(e.alu));
          end
          m_cyc = 0; m_regw = 0; m_memw = 0; m_pcw = 0; m_ill = 0; m_alu = '0;
        end
      end
    end
  end

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic [3:0] cond, input logic [3:0] af);
    bus.op = op; bus.funct = funct; bus.rd = rd; bus.cond = cond; bus.alu_flags = af;
  endtask

  task automatic wait_done(input int id);
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (bus.instr_done) done = 1'b1;
    end
    if (!done) begin
      chk("timeout", id, 0, 1);
      if (q.size() > 0) void'(q.pop_back());
    end
    @(posedge clk); #1;
  endtask

  // Called with the DUT in FETCH, at posedge+1.
  task automatic run(input int id, input logic [1:0] op, input logic [5:0] funct,
                     input logic [3:0] rd, input logic [3:0] cond, input logic [3:0] af,
                     input int cyc, input int regw, input int memw, input int pcw,
                     input int ill, input logic [1:0] rs, input logic [2:0] alu);
    exp_t e;
    e.id = id; e.cyc = cyc; e.regw = regw; e.memw = memw; e.pcw = pcw;
    e.ill = ill; e.rs = rs; e.alu = alu;
    q.push_back(e);
    set_instr(op, funct, rd, cond, af);
    wait_done(id);
  endtask

  initial begin
    logic [1:0] imm_exp [4];
    logic [1:0] rsrc_exp[4];
    imm_exp  = '{2'b00, 2'b01, 2'b10, 2'b11};
    rsrc_exp = '{2'b00, 2'b10, 2'b01, 2'b00};
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    set_instr(2'b00, 6'b001000, 4'd1, 4'hE, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ir_write",   0, int'(bus.ir_write),   0);
    chk("rst_pc_write",   0, int'(bus.pc_write),   0);
    chk("rst_reg_w",      0, int'(bus.reg_w),      0);
    chk("rst_instr_done", 0, int'(bus.instr_done), 0);
    for (int i = 0; i < 4; i++) begin
      bus.op = 2'(i);
      #1;
      chk("imm_src", i, int'(bus.imm_src), int'(imm_exp[i]));
      chk("reg_src", i, int'(bus.reg_src), int'(rsrc_exp[i]));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("fetch_ir_write", 0, int'(bus.ir_write), 1);

    //   id  op     funct      rd     cond   aflags cyc rw mw pcw ill rs     alu
    run( 1, 2'b00, 6'b001000, 4'd1,  4'hE, 4'h0, 4, 1, 0, 1, 0, 2'b00, 3'b000); // ADD
    run( 2, 2'b01, 6'b000001, 4'd2,  4'hE, 4'h0, 5, 1, 0, 1, 0, 2'b01, 3'b000); // LDR
    run( 3, 2'b01, 6'b000000, 4'd2,  4'hE, 4'h0, 4, 0, 1, 1, 0, 2'b00, 3'b000); // STR
    run( 4, 2'b00, 6'b000101, 4'd3,  4'hE, 4'h4, 4, 1, 0, 1, 0, 2'b00, 3'b001); // SUBS Z=1
    run( 5, 2'b10, 6'b000000, 4'd0,  4'h0, 4'h0, 3, 0, 0, 2, 0, 2'b10, 3'b000); // BEQ taken
    run( 6, 2'b00, 6'b000101, 4'd3,  4'hE, 4'h0, 4, 1, 0, 1, 0, 2'b00, 3'b001); // SUBS Z=0
    run( 7, 2'b10, 6'b000000, 4'd0,  4'h0, 4'h0, 3, 0, 0, 1, 0, 2'b10, 3'b000); // BEQ not taken
    run( 8, 2'b00, 6'b010101, 4'd0,  4'hE, 4'h4, 4, 0, 0, 1, 0, 2'b00, 3'b001); // CMP Z=1
    run( 9, 2'b10, 6'b000000, 4'd0,  4'h1, 4'h0, 3, 0, 0, 1, 0, 2'b10, 3'b000); // BNE not taken
    run(10, 2'b00, 6'b001000, 4'd15, 4'hE, 4'h0, 4, 1, 0, 2, 0, 2'b00, 3'b000); // ADD PC
    run(11, 2'b00, 6'b001000, 4'd1,  4'h1, 4'h0, 4, 0, 0, 1, 0, 2'b00, 3'b000); // ADDNE false
    run(12, 2'b01, 6'b000000, 4'd2,  4'h1, 4'h0, 4, 0, 0, 1, 0, 2'b00, 3'b000); // STRNE false
    run(13, 2'b11, 6'b000000, 4'd0,  4'hE, 4'h0, 2, 0, 0, 1, 1, 2'b10, 3'b000); // op=11
    run(14, 2'b00, 6'b000010, 4'd1,  4'hE, 4'h0, 2, 0, 0, 1, 1, 2'b10, 3'b000); // bad cmd
    run(15, 2'b00, 6'b111000, 4'd4,  4'hE, 4'h0, 4, 1, 0, 1, 0, 2'b00, 3'b011); // ORR imm
    run(16, 2'b00, 6'b000000, 4'd5,  4'hE, 4'h0, 4, 1, 0, 1, 0, 2'b00, 3'b010); // AND
    run(17, 2'b00, 6'b000101, 4'd3,  4'hE, 4'h8, 4, 1, 0, 1, 0, 2'b00, 3'b001); // SUBS N=1
    run(18, 2'b10, 6'b000000, 4'd0,  4'hB, 4'h0, 3, 0, 0, 2, 0, 2'b10, 3'b000); // BLT taken
    run(19, 2'b00, 6'b000001, 4'd5,  4'hE, 4'h3, 4, 1, 0, 1, 0, 2'b00, 3'b010); // ANDS: C,V kept
    run(20, 2'b10, 6'b000000, 4'd0,  4'h2, 4'h0, 3, 0, 0, 1, 0, 2'b10, 3'b000); // BCS not taken
    run(21, 2'b10, 6'b000000, 4'd0,  4'hA, 4'h0, 3, 0, 0, 2, 0, 2'b10, 3'b000); // BGE taken
    run(22, 2'b00, 6'b001000, 4'd1,  4'hF, 4'h0, 4, 0, 0, 1, 0, 2'b00, 3'b000); // cond 1111
    run(23, 2'b00, 6'b001001, 4'd1,  4'h0, 4'h4, 4, 0, 0, 1, 0, 2'b00, 3'b000); // ADDSEQ false
    run(24, 2'b10, 6'b000000, 4'd0,  4'h0, 4'h0, 3, 0, 0, 1, 0, 2'b10, 3'b000); // BEQ not taken

    // Reset while an LDR sits in MEMWB: the pending register write must not appear.
    set_instr(2'b01, 6'b000001, 4'd2, 4'hE, 4'h0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_reg_w",    25, int'(bus.reg_w),      0);
    chk("midrst_pc_write", 25, int'(bus.pc_write),   0);
    chk("midrst_done",     25, int'(bus.instr_done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run(26, 2'b00, 6'b001000, 4'd1,  4'hE, 4'h0, 4, 1, 0, 1, 0, 2'b00, 3'b000); // ADD after reset

`ifdef MULTICYCLE_MEM_WAIT_EN
    begin
      exp_t e;
      e.id = 27; e.cyc = 8; e.regw = 1; e.memw = 0; e.pcw = 1; e.ill = 0;
      e.rs = 2'b01; e.alu = 3'b000;
      q.push_back(e);
      set_instr(2'b01, 6'b000001, 4'd2, 4'hE, 4'h0);
      repeat (3) @(posedge clk);
      #1 bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("wait_adr_src", 27, int'(bus.adr_src), 1);
        chk("wait_reg_w",   27, int'(bus.reg_w),   0);
      end
      @(posedge clk); #1 bus.mem_ready = 1'b1;
      wait_done(27);
      set_instr(2'b01, 6'b000000, 4'd2, 4'hE, 4'h0);
      repeat (3) @(posedge clk);
      #1 bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("wait_mem_w", 28, int'(bus.mem_w), 0);
      @(posedge clk); #1 rst_n = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_memwr_mem_w", 28, int'(bus.mem_w), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      run(29, 2'b00, 6'b001000, 4'd1, 4'hE, 4'h0, 4, 1, 0, 1, 0, 2'b00, 3'b000);
    end
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", 0, q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
